// File: rtl/c3po_egress_narrow.sv
// rtl/c3po_egress_narrow.sv - re-emits 32-byte c3po beats as 8-byte egress slices
//
// Holds one input beat and presents it as ceil(vbc/OUT_BYTES_P) slices.
// It drops malformed beats and counts errors and completed packets.
// Optional build macro C3PO_EGRESS_PARITY_EN adds the sig_o_par output.
//
// Ports:
//   sig_clock, sig_reset           clock, synchronous active-high reset
//   sig_i_sop/eop/val/vbc/data     input beat (IN_BYTES_P bytes, byte 0 in [7:0])
//   sig_i_ready                    beat accepted when sig_i_val & sig_i_ready
//   sig_o_sop/eop/val/vbc/data     output slice (OUT_BYTES_P bytes)
//   sig_o_par                      per-byte even parity of the slice (macro only)
//   sig_o_ready                    slice transfers when sig_o_val & sig_o_ready
//   sig_pkt_cnt, sig_err_cnt       saturating packet / error counters
//   sig_idle                       no beat held and no packet open
module c3po_egress_narrow #(
   parameter int IN_BYTES_P  = 32,
   parameter int OUT_BYTES_P = 8,
   parameter int CNT_SIZE_P  = 8
) (
   input  logic                     sig_clock,
   input  logic                     sig_reset,
   input  logic                     sig_i_sop,
   input  logic                     sig_i_eop,
   input  logic                     sig_i_val,
   input  logic [7:0]               sig_i_vbc,
   input  logic [IN_BYTES_P*8-1:0]  sig_i_data,
   output logic                     sig_i_ready,
   output logic                     sig_o_sop,
   output logic                     sig_o_eop,
   output logic                     sig_o_val,
   output logic [3:0]               sig_o_vbc,
   output logic [OUT_BYTES_P*8-1:0] sig_o_data,
`ifdef C3PO_EGRESS_PARITY_EN
   output logic [OUT_BYTES_P-1:0]   sig_o_par,
`endif
   input  logic                     sig_o_ready,
   output logic [CNT_SIZE_P-1:0]    sig_pkt_cnt,
   output logic [CNT_SIZE_P-1:0]    sig_err_cnt,
   output logic                     sig_idle
);

   localparam int NSLICE_MAX = IN_BYTES_P / OUT_BYTES_P;
   localparam int K_W        = (NSLICE_MAX > 1) ? $clog2(NSLICE_MAX) : 1;
   localparam int OUT_W      = OUT_BYTES_P * 8;
   localparam logic [7:0] IN_BYTES_V = 8'(IN_BYTES_P);

   typedef enum logic {ST_IDLE, ST_SEND} state_t;

   state_t                  state_q, state_d;
   logic [K_W-1:0]          k_q, k_d;
   logic [IN_BYTES_P*8-1:0] data_q, data_d;
   logic [7:0]              vbc_q, vbc_d;
   logic                    sop_q, sop_d;
   logic                    eop_q, eop_d;
   logic                    in_pkt_q, in_pkt_d;
   logic                    idle_q, idle_d;
   logic [CNT_SIZE_P-1:0]   pkt_cnt_q, pkt_cnt_d;
   logic [CNT_SIZE_P-1:0]   err_cnt_q, err_cnt_d;

   logic [7:0] nslice;
   logic [7:0] slice_base;
   logic [7:0] rem_bytes;
   logic       last_slice;
   logic       xfer, eop_xfer, accept, in_pkt_eff;
   logic       err_a, err_b, err_c, err_d, drop;

   assign nslice     = 8'((9'(vbc_q) + 9'(OUT_BYTES_P - 1)) / 9'(OUT_BYTES_P));
   assign slice_base = 8'(k_q) * 8'(OUT_BYTES_P);
   assign rem_bytes  = vbc_q - slice_base;
   assign last_slice = (state_q == ST_SEND) && (8'(k_q) == nslice - 8'd1);

   // Output slice is a pure function of the held beat and k, so it stays
   // stable for as long as the downstream stalls.
   always_comb begin
      sig_o_val  = 1'b0;
      sig_o_sop  = 1'b0;
      sig_o_eop  = 1'b0;
      sig_o_vbc  = 4'd0;
      sig_o_data = '0;
      if (state_q == ST_SEND) begin
         sig_o_val  = 1'b1;
         sig_o_sop  = sop_q && (k_q == '0);
         sig_o_eop  = eop_q && last_slice;
         sig_o_vbc  = last_slice ? 4'(rem_bytes) : 4'(OUT_BYTES_P);
         sig_o_data = data_q[int'(k_q)*OUT_W +: OUT_W];
      end
   end

`ifdef C3PO_EGRESS_PARITY_EN
   always_comb begin
      sig_o_par = '0;
      for (int i = 0; i < OUT_BYTES_P; i++) begin
         if (i < int'(sig_o_vbc)) begin
            sig_o_par[i] = ^sig_o_data[i*8 +: 8];
         end
      end
   end
`endif

   assign xfer     = sig_o_val & sig_o_ready;
   assign eop_xfer = xfer & sig_o_eop;

   // A new beat may slide in on the cycle the last slice leaves, which keeps
   // full beats back-to-back without a bubble.
   assign sig_i_ready = ~sig_reset & ((state_q == ST_IDLE) | (last_slice & sig_o_ready));
   assign accept      = sig_i_val & sig_i_ready;

   // A packet whose eop slice leaves this cycle is already closed as far as
   // a beat accepted in the same cycle is concerned.
   assign in_pkt_eff = in_pkt_q & ~eop_xfer;

   assign err_a = (sig_i_vbc == 8'd0) || (sig_i_vbc > IN_BYTES_V);
   assign err_b = ~sig_i_eop && (sig_i_vbc != IN_BYTES_V);
   assign err_c = ~sig_i_sop & ~in_pkt_eff;
   assign err_d = sig_i_sop & in_pkt_eff;
   assign drop  = err_a | err_b | err_c;

   always_comb begin
      state_d   = state_q;
      k_d       = k_q;
      data_d    = data_q;
      vbc_d     = vbc_q;
      sop_d     = sop_q;
      eop_d     = eop_q;
      in_pkt_d  = in_pkt_q;
      pkt_cnt_d = pkt_cnt_q;
      err_cnt_d = err_cnt_q;

      if (xfer) begin
         if (last_slice) begin
            state_d = ST_IDLE;
         end else begin
            k_d = k_q + K_W'(1);
         end
      end

      if (eop_xfer) begin
         in_pkt_d = 1'b0;
         if (pkt_cnt_q != '1) begin
            pkt_cnt_d = pkt_cnt_q + CNT_SIZE_P'(1);
         end
      end

      if (accept) begin
         if (drop) begin
            // A bad-length eop beat still terminates the open packet.
            if (err_a && sig_i_eop) begin
               in_pkt_d = 1'b0;
            end
         end else begin
            state_d = ST_SEND;
            k_d     = '0;
            data_d  = sig_i_data;
            vbc_d   = sig_i_vbc;
            sop_d   = sig_i_sop;
            eop_d   = sig_i_eop;
            if (sig_i_sop) begin
               in_pkt_d = 1'b1;
            end
         end
         if ((drop || err_d) && (err_cnt_q != '1)) begin
            err_cnt_d = err_cnt_q + CNT_SIZE_P'(1);
         end
      end

      idle_d = (state_d == ST_IDLE) && !in_pkt_d;
   end

   always_ff @(posedge sig_clock) begin
      if (sig_reset) begin
         state_q   <= ST_IDLE;
         k_q       <= '0;
         data_q    <= '0;
         vbc_q     <= '0;
         sop_q     <= 1'b0;
         eop_q     <= 1'b0;
         in_pkt_q  <= 1'b0;
         idle_q    <= 1'b1;
         pkt_cnt_q <= '0;
         err_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         k_q       <= k_d;
         data_q    <= data_d;
         vbc_q     <= vbc_d;
         sop_q     <= sop_d;
         eop_q     <= eop_d;
         in_pkt_q  <= in_pkt_d;
         idle_q    <= idle_d;
         pkt_cnt_q <= pkt_cnt_d;
         err_cnt_q <= err_cnt_d;
      end
   end

   assign sig_pkt_cnt = pkt_cnt_q;
   assign sig_err_cnt = err_cnt_q;
   assign sig_idle    = idle_q;

endmodule
